// File: rtl/seq_stim_gen.sv
// Initiator-side stimulus generator for the or/and/intersect sequence checker.
// Emits rose (a -> c/b pulses) and pair (a,c,e then b,d) transactions from registered outputs.
module seq_stim_gen #(
   parameter int B_DLY = 3,
   parameter int C_DLY = 1,
   parameter int GAP   = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic mode,
   output logic busy,
   output logic done,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e
);

   localparam int MAX_DLY = (B_DLY > C_DLY) ? B_DLY : C_DLY;
   localparam int CNT_TOP = (GAP > 5) ? GAP : 5;
   localparam int CNT_W   = $clog2(CNT_TOP + 1);

   localparam logic [CNT_W-1:0] B_CNT    = CNT_W'(B_DLY);
   localparam logic [CNT_W-1:0] C_CNT    = CNT_W'(C_DLY);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_DLY);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

   if (B_DLY < 1 || B_DLY > 5) begin : g_bad_b_dly
      $error("seq_stim_gen: B_DLY must be in 1..5");
   end
   if (C_DLY < 1 || C_DLY > 2) begin : g_bad_c_dly
      $error("seq_stim_gen: C_DLY must be in 1..2");
   end
   if (GAP < 1) begin : g_bad_gap
      $error("seq_stim_gen: GAP must be at least 1");
   end

   typedef enum logic [2:0] {IDLE, ROSE, PAIR0, PAIR1, GAPW} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             accept;

   assign cnt_inc = cnt + CNT_W'(1);

   // The edge that closes the gap behaves as the first IDLE edge, so a held
   // start re-launches without an extra idle cycle.
   assign accept = start && ((state == IDLE) || (state == GAPW && cnt == GAP_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         a     <= 1'b0;
         b     <= 1'b0;
         c     <= 1'b0;
         d     <= 1'b0;
         e     <= 1'b0;
      end else begin
         done <= 1'b0;
         a    <= 1'b0;
         b    <= 1'b0;
         c    <= 1'b0;
         d    <= 1'b0;
         e    <= 1'b0;
         if (accept) begin
            busy <= 1'b1;
            cnt  <= '0;
            a    <= 1'b1;
            if (mode) begin
               state <= PAIR0;
               c     <= 1'b1;
               e     <= 1'b1;
            end else begin
               state <= ROSE;
            end
         end else begin
            case (state)
               IDLE: busy <= 1'b0;
               ROSE: begin
                  if (cnt == MAX_CNT) begin
                     state <= GAPW;
                     cnt   <= '0;
                  end else begin
                     cnt  <= cnt_inc;
                     a    <= 1'b1;
                     b    <= (cnt_inc == B_CNT);
                     c    <= (cnt_inc == C_CNT);
                     done <= (cnt_inc == MAX_CNT);
                  end
               end
               PAIR0: begin
                  state <= PAIR1;
                  b     <= 1'b1;
                  d     <= 1'b1;
                  done  <= 1'b1;
               end
               PAIR1: begin
                  state <= GAPW;
                  cnt   <= '0;
               end
               GAPW: begin
                  if (cnt == GAP_LAST) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_seq_stim_gen.sv
// Bench for seq_stim_gen: default instance and a (B=5,C=2,GAP=1) instance share
// stimulus; each is compared every cycle with a transaction-level reference model.
module tb_seq_stim_gen;

   logic clk;
   logic rst_n;
   logic start;
   logic mode;
   logic busy1, done1, a1, b1, c1, d1, e1;
   logic busy2, done2, a2, b2, c2, d2, e2;
   logic [6:0] o1, o2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state per instance: 0 = defaults, 1 = (5,2,1)
   int pb [2] = '{3, 5};
   int pc [2] = '{1, 2};
   int pg [2] = '{2, 1};
   bit has[2];
   int s0 [2];
   bit m  [2];

   seq_stim_gen dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .busy(busy1), .done(done1), .a(a1), .b(b1), .c(c1), .d(d1), .e(e1)
   );

   seq_stim_gen #(.B_DLY(5), .C_DLY(2), .GAP(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .busy(busy2), .done(done2), .a(a2), .b(b2), .c(c2), .d(d2), .e(e2)
   );

   assign o1 = {busy1, done1, a1, b1, c1, d1, e1};
   assign o2 = {busy2, done2, a2, b2, c2, d2, e2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int txn_len(int k);
      int mx;
      mx = (pb[k] > pc[k]) ? pb[k] : pc[k];
      return m[k] ? 2 : mx + 1;
   endfunction

   // Expected {busy,done,a,b,c,d,e} in cycle t, from the transaction's offset.
   function automatic logic [6:0] model_out(int k, int t);
      int off, len, mx;
      logic [6:0] v;
      v = '0;
      if (!has[k]) return v;
      off = t - s0[k];
      len = txn_len(k);
      mx  = (pb[k] > pc[k]) ? pb[k] : pc[k];
      if (off < len) begin
         if (m[k]) begin
            v = (off == 0) ? 7'b1010101 : 7'b1101010;
         end else begin
            v[6] = 1'b1;
            v[5] = (off == mx);
            v[4] = 1'b1;
            v[3] = (off == pb[k]);
            v[2] = (off == pc[k]);
         end
      end else if (off < len + pg[k]) begin
         v[6] = 1'b1;
      end
      return v;
   endfunction

   // Can a start sampled at the edge after cycle t be taken?
   function automatic bit can_accept(int k, int t);
      if (!has[k]) return 1'b1;
      return (t - s0[k]) >= txn_len(k) + pg[k] - 1;
   endfunction

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input logic st, input logic md);
      start = st;
      mode  = md;
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         if (st && can_accept(k, cyc - 1)) begin
            has[k] = 1'b1;
            s0[k]  = cyc;
            m[k]   = md;
         end
      end
      #1;
      check("model_dut1", o1, model_out(0, cyc));
      check("model_dut2", o2, model_out(1, cyc));
   endtask

   // Asynchronous reset pulse in the middle of the current cycle.
   task automatic mid_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_dut1", o1, 7'b0);
      check("async_reset_dut2", o2, 7'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      has[0] = 1'b0;
      has[1] = 1'b0;
   endtask

   logic [6:0] rose1 [0:6] = '{7'b1010000, 7'b1010100, 7'b1010000, 7'b1111000,
                               7'b1000000, 7'b1000000, 7'b0000000};
   logic [6:0] rose2 [0:7] = '{7'b1010000, 7'b1010000, 7'b1010100, 7'b1010000,
                               7'b1010000, 7'b1111000, 7'b1000000, 7'b0000000};
   logic [6:0] pair1 [0:4] = '{7'b1010101, 7'b1101010, 7'b1000000, 7'b1000000, 7'b0000000};
   logic [6:0] pair2 [0:3] = '{7'b1010101, 7'b1101010, 7'b1000000, 7'b0000000};

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 1'b0;
      has[0] = 1'b0;
      has[1] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_dut1", o1, 7'b0);
      check("reset_dut2", o2, 7'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step(1'b0, 1'b0);

      // Rose transaction with fixed-offset anchors for both instances
      step(1'b1, 1'b0);
      check("rose_anchor1_0", o1, rose1[0]);
      check("rose_anchor2_0", o2, rose2[0]);
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b0);
         if (i < 7) check("rose_anchor1", o1, rose1[i]);
         check("rose_anchor2", o2, rose2[i]);
      end

      // start pulses while busy are dropped
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      repeat (4) step(1'b0, 1'b0);

      // Pair transaction
      step(1'b1, 1'b1);
      check("pair_anchor1_0", o1, pair1[0]);
      check("pair_anchor2_0", o2, pair2[0]);
      for (int i = 1; i < 5; i++) begin
         step(1'b0, 1'b0);
         check("pair_anchor1", o1, pair1[i]);
         if (i < 4) check("pair_anchor2", o2, pair2[i]);
      end

      // start held high: back-to-back rose transactions on dut1
      step(1'b1, 1'b0);
      for (int i = 1; i < 10; i++) begin
         step(1'b1, 1'b0);
         if (i == 6) check("held_relaunch_dut1", o1, 7'b1010000);
         if (i == 9) check("held_second_done", {o1[5], o1[3]}, 2'b11);
      end
      repeat (6) step(1'b0, 1'b0);

      // Reset mid-transaction, then immediate acceptance
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      mid_reset();
      step(1'b1, 1'b0);
      check("post_reset_accept", o1, 7'b1010000);
      repeat (8) step(1'b0, 1'b0);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 59) == 0) mid_reset();
      end
      repeat (10) step(1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_stim_gen.md
Name: seq_stim_gen

Overview:
- Initiator-side sequence generator for the multi-sequence or/and/intersect checker block.
- Drives the a/b/c/d/e handshake lines so that every transaction it produces satisfies the checker's properties:
  - $rose(a) ##[1:5] b
  - $rose(a) ##[1:2] c
  - e |-> (a ##1 b) intersect (c ##1 d)
- Sits between the test sequencer (start/mode) and the checker-monitored signal bundle.

Parameters:
- B_DLY, 3: cycles from the rise of a to the b pulse; legal range 1..5.
- C_DLY, 1: cycles from the rise of a to the c pulse; legal range 1..2.
- GAP, 2: idle cycles with all outputs low after each transaction; minimum 1.

Ports:
- clk  input  1  sole clock; all flops on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  transaction request; sampled only in IDLE.
- mode  input  1  0 = rose transaction, 1 = pair transaction; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the last active cycle of a transaction.
- a  output  1  request line.
- b  output  1  response line 1.
- c  output  1  response line 2.
- d  output  1  pair completion line.
- e  output  1  pair trigger line.

Behaviour:
- All outputs are driven directly from flops; no combinational paths from inputs to outputs.
- Reset (rst_n low, asynchronous):
  - state = IDLE, counter = 0.
  - a, b, c, d, e, done, busy all 0.
  - Reset asserted mid-transaction aborts it immediately. No done pulse is produced.
- States: IDLE, ROSE, PAIR0, PAIR1, GAPW.
- IDLE:
  - start=1 at edge k, mode=0: enter ROSE at k, cnt=0.
  - start=1 at edge k, mode=1: enter PAIR0 at k.
  - start=0: stay in IDLE.
- ROSE:
  - a=1 for the whole state. a was 0 in the previous cycle, so $rose(a) holds in the first ROSE cycle.
  - cnt increments every cycle.
  - b=1 exactly in the cycle cnt==B_DLY.
  - c=1 exactly in the cycle cnt==C_DLY.
  - If B_DLY==C_DLY, b and c pulse together.
  - In the cycle cnt==max(B_DLY,C_DLY): done=1, and the next state is GAPW.
  - d=0 and e=0 throughout.
- PAIR0: a=1, c=1, e=1, b=0, d=0. Always advances to PAIR1.
- PAIR1: b=1, d=1, a=0, c=0, e=0, done=1. Always advances to GAPW.
- GAPW:
  - All lines low, including a; this guarantees a fresh $rose on the next transaction.
  - Lasts exactly GAP cycles, counted by cnt, then returns to IDLE.
- start while busy (ROSE, PAIR0, PAIR1, GAPW):
  - Ignored and not queued.
  - mode is ignored outside the accepting edge.
- start held high continuously: a new transaction is accepted on the first edge in IDLE after the gap.
- Counter: 3 bits, wide enough for max(5, GAP) when GAP ≤ 7. Width is derived as $clog2(max(5,GAP)+1).
- Parameter checks: out-of-range B_DLY, C_DLY or GAP raises an elaboration-time $error.

Test Plan:
1. Rose transaction, defaults (B_DLY=3, C_DLY=1, GAP=2); start pulsed one cycle, accepted at edge 10.
   - a=1 in cycles 10–13.
   - c=1 in cycle 11 only; b=1 in cycle 13 only; done=1 in cycle 13.
   - Cycles 14–15: all outputs low, busy=1.
   - Cycle 16: busy=0.
2. Rose transaction with B_DLY=5, C_DLY=2, GAP=1, accepted at edge 0.
   - c in cycle 2; b and done in cycle 5; a=1 in cycles 0–5.
   - Cycle 6: gap; busy=0 in cycle 7.
   - Checker ap_1 and ap_b pass.
3. Pair transaction: mode=1 with start, accepted at edge 20.
   - Cycle 20: a=c=e=1.
   - Cycle 21: b=d=done=1, a=c=e=0.
   - busy=0 from cycle 24.
   - Checker apxx passes.
4. start pulsed in cycles 11 and 14 during the test-1 transaction: ignored.
   - Output trace is identical to test 1.
   - No second a rise before cycle 16.
5. start held high from cycle 10 with defaults.
   - a high in cycles 10–13, low in 14–15, high again at 16.
   - Second done in cycle 19.
6. rst_n driven low in cycle 12 of test 1, asynchronously mid-cycle.
   - All outputs 0 immediately, busy=0, no done.
   - After release, a start is accepted on the first edge in IDLE.
